// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder (one full_adder, LSB first) behind a valid/ready handshake
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_ovf;
`endif

    assign w_bit_a   = r_a[r_cnt];
    assign w_bit_b   = r_b[r_cnt];
    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_state == RUN) && (r_cnt == LAST_BIT);
    assign w_release = (r_state == DONE) && out_ready;

    full_adder u_full_adder (
        .i_a    (w_bit_a),
        .i_b    (w_bit_b),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (w_release) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The counter parks on the last bit rather than wrapping; it is reloaded on the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sum[r_cnt] <= w_s;
                r_carry      <= w_c;
                if (w_last) begin
                    r_cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                    r_ovf  <= r_carry ^ w_c;
`endif
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// Single-bit full adder shared by the serial datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (vector table, corner sequences, random ops)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from the two's-complement sign rule.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full};
    endfunction

    function automatic logic current_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic scramble_inputs();
        in_valid  = 1'($urandom);
        a         = W'({$urandom, $urandom});
        b         = W'({$urandom, $urandom});
        cin       = 1'($urandom);
    endtask

    // Called at a negedge. Issues one op, counts edges to out_valid, stalls 'hold' cycles, then handshakes.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int hold,
                         output logic [W-1:0] rs, output logic rc, output logic ro, output int lat);
        int           t;
        logic [W-1:0] s0;
        logic         c0;
        logic         o0;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'($urandom);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 4 * W) begin
            scramble_inputs();
            out_ready = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        s0 = sum; c0 = cout; o0 = current_ovf();
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            @(posedge clk);
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_out_valid", 64'(out_valid), 64'(1));
            chk("hold_sum", 64'(sum), 64'(s0));
            chk("hold_cout", 64'(cout), 64'(c0));
            chk("hold_ovf", 64'(current_ovf()), 64'(o0));
        end
        rs = sum; rc = cout; ro = current_ovf();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_in_ready", 64'(in_ready), 64'(1));
        chk("post_hs_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t         vecs[7];
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        int           lat;
        logic [W+1:0] e;
        int           cnt_ov;
        logic [W+1:0] exp_q[$];
        int           n_acc;
        int           n_out;
        int           cyc;
        int           last_acc;
        logic         prev_take;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 5};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
        vecs[6] = '{8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1, 2};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(current_ovf()), 64'(0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, rs, rc, ro, lat);
            chk("vec_latency", 64'(lat), 64'(W));
            chk("vec_sum", 64'(rs), 64'(vecs[i].s));
            chk("vec_cout", 64'(rc), 64'(vecs[i].co));
`ifdef SERIAL_ADDER_OVF_EN
            chk("vec_ovf", 64'(ro), 64'(vecs[i].ov));
`endif
        end

        // Reset while bit 3 is next to be processed.
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        chk("midrst_ovf", 64'(current_ovf()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt_ov = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) cnt_ov++;
        end
        chk("midrst_no_out_valid", 64'(cnt_ov), 64'(0));
        do_op(8'h55, 8'hAA, 1'b0, 0, rs, rc, ro, lat);
        chk("after_rst_latency", 64'(lat), 64'(W));
        chk("after_rst_sum", 64'(rs), 64'(8'hFF));
        chk("after_rst_cout", 64'(rc), 64'(0));

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rcin;
            ra = W'({$urandom, $urandom}); rb = W'({$urandom, $urandom}); rcin = 1'($urandom);
            e = ref_add(ra, rb, rcin);
            do_op(ra, rb, rcin, int'($urandom_range(0, 2)), rs, rc, ro, lat);
            chk("rand_latency", 64'(lat), 64'(W));
            chk("rand_sum", 64'(rs), 64'(e[W-1:0]));
            chk("rand_cout", 64'(rc), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
            chk("rand_ovf", 64'(ro), 64'(e[W+1]));
`endif
        end

        // Back-to-back with in_valid and out_ready held high.
        n_acc = 0; n_out = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom}); cin = 1'($urandom); in_valid = 1'b1;
        while (n_out < 100 && cyc < 100 * (W + 2) + 100) begin
            prev_take = in_ready && in_valid;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (prev_take) begin
                exp_q.push_back(ref_add(a, b, cin));
                if (last_acc >= 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'(W + 2));
                last_acc = cyc;
                n_acc++;
                if (n_acc < 100) begin
                    a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom}); cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b_sum", 64'(sum), 64'(e[W-1:0]));
                    chk("b2b_cout", 64'(cout), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("b2b_ovf", 64'(current_ovf()), 64'(e[W+1]));
`endif
                end
                n_out++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'(100));
        chk("b2b_results", 64'(n_out), 64'(100));
        chk("b2b_pending", 64'(exp_q.size()), 64'(0));
        chk("b2b_end_idle", 64'(in_ready), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
